// File: rtl/pla_timing_sequencer.sv
// One-hot T0..T5 cycle sequencer and instruction register for the 6502 decode PLA.
// Define PLA_SEQ_IRQ_EN to force RESET_OPCODE into IR when an interrupt is pending at fetch.
module pla_timing_sequencer #(
    parameter logic [7:0] RESET_OPCODE = 8'h00
) (
    input  logic       GlobalClock,
    input  logic       Reset,
    input  logic       ClockEnable,
    input  logic       Rdy,
    input  logic       Read_Cycle,
    input  logic       End_Instr,
    input  logic       Irq_Pending,
    input  logic [7:0] Data_In,
    output logic [5:0] T_State,
    output logic       Sync,
    output logic [7:0] IR,
    output logic       In_Interrupt,
    output logic       Int_Taken,
    output logic       Seq_Error
);

    typedef enum logic [5:0] {
        T0 = 6'b000001,
        T1 = 6'b000010,
        T2 = 6'b000100,
        T3 = 6'b001000,
        T4 = 6'b010000,
        T5 = 6'b100000
    } t_state_e;

    t_state_e state;
    logic     advance;
    logic     irq_take;

    // Read cycles wait for the bus; write cycles never stall.
    assign advance = ClockEnable & (Rdy | ~Read_Cycle);

`ifdef PLA_SEQ_IRQ_EN
    assign irq_take = Irq_Pending;
`else
    assign irq_take = Irq_Pending & 1'b0;
`endif

    assign T_State = state;
    assign Sync    = state[0];

    always_ff @(posedge GlobalClock or posedge Reset) begin
        if (Reset) begin
            state        <= T0;
            IR           <= RESET_OPCODE;
            In_Interrupt <= 1'b0;
            Int_Taken    <= 1'b0;
            Seq_Error    <= 1'b0;
        end else begin
            Int_Taken <= 1'b0;
            if (advance) begin
                unique case (state)
                    T0: begin
                        state        <= T1;
                        IR           <= irq_take ? RESET_OPCODE : Data_In;
                        In_Interrupt <= irq_take;
                        Int_Taken    <= irq_take;
                    end
                    T1: state <= End_Instr ? T0 : T2;
                    T2: state <= End_Instr ? T0 : T3;
                    T3: state <= End_Instr ? T0 : T4;
                    T4: state <= End_Instr ? T0 : T5;
                    T5: begin
                        // No T6 exists: wrap to fetch and flag the overrun.
                        state <= T0;
                        if (!End_Instr) Seq_Error <= 1'b1;
                    end
                    default: state <= T0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pla_timing_sequencer.sv
// Directed and randomized bench for pla_timing_sequencer against a cycle-count model.
// The model honours PLA_SEQ_IRQ_EN the same way the build does.
module tb_pla_timing_sequencer;

    logic       GlobalClock = 1'b0;
    logic       Reset;
    logic       ClockEnable;
    logic       Rdy;
    logic       Read_Cycle;
    logic       End_Instr;
    logic       Irq_Pending;
    logic [7:0] Data_In;
    logic [5:0] T_State;
    logic       Sync;
    logic [7:0] IR;
    logic       In_Interrupt;
    logic       Int_Taken;
    logic       Seq_Error;

    int vectors = 0;
    int miscompares = 0;

    int         m_n;
    logic [7:0] m_ir;
    logic       m_inint;
    logic       m_taken;
    logic       m_err;

`ifdef PLA_SEQ_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    pla_timing_sequencer dut (
        .GlobalClock (GlobalClock),
        .Reset       (Reset),
        .ClockEnable (ClockEnable),
        .Rdy         (Rdy),
        .Read_Cycle  (Read_Cycle),
        .End_Instr   (End_Instr),
        .Irq_Pending (Irq_Pending),
        .Data_In     (Data_In),
        .T_State     (T_State),
        .Sync        (Sync),
        .IR          (IR),
        .In_Interrupt(In_Interrupt),
        .Int_Taken   (Int_Taken),
        .Seq_Error   (Seq_Error)
    );

    always #5 GlobalClock = ~GlobalClock;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] exp_t;
        exp_t = 8'(1 << m_n);
        chk({tag, ".T_State"}, {2'b00, T_State}, exp_t);
        chk({tag, ".Sync"}, {7'd0, Sync}, {7'd0, m_n == 0});
        chk({tag, ".IR"}, IR, m_ir);
        chk({tag, ".In_Interrupt"}, {7'd0, In_Interrupt}, {7'd0, m_inint});
        chk({tag, ".Int_Taken"}, {7'd0, Int_Taken}, {7'd0, m_taken});
        chk({tag, ".Seq_Error"}, {7'd0, Seq_Error}, {7'd0, m_err});
    endtask

    task automatic model_reset();
        m_n = 0;
        m_ir = 8'h00;
        m_inint = 1'b0;
        m_taken = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic drive(input logic ce, input logic rdy, input logic rd,
                         input logic ei, input logic irq,
                         input logic [7:0] din);
        ClockEnable = ce;
        Rdy = rdy;
        Read_Cycle = rd;
        End_Instr = ei;
        Irq_Pending = irq;
        Data_In = din;
    endtask

    // Model: cycle index within the instruction, 0 = fetch.
    task automatic step(input string tag);
        bit adv;
        bit irq;
        adv = ClockEnable && (Rdy || !Read_Cycle);
        irq = IRQ_EN && Irq_Pending;
        m_taken = 1'b0;
        if (adv) begin
            if (m_n == 0) begin
                m_ir = irq ? 8'h00 : Data_In;
                m_inint = irq;
                m_taken = irq;
                m_n = 1;
            end else if (m_n == 5) begin
                if (!End_Instr) m_err = 1'b1;
                m_n = 0;
            end else begin
                m_n = End_Instr ? 0 : m_n + 1;
            end
        end
        @(posedge GlobalClock);
        #1;
        check_all(tag);
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        #3;
        model_reset();
        check_all("reset");
        @(negedge GlobalClock);
        Reset = 1'b0;

        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA9);
        step("lda_t0");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11);
        step("lda_t1");

        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h20);
        step("six_t0");
        for (int i = 1; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
            step("six_mid");
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
        step("six_t5");

        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h6C);
        for (int i = 0; i < 6; i++) step("overrun");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55);
        step("err_sticky_t0");
        step("err_sticky_t1");

        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h4C);
        for (int i = 0; i < 3; i++) step("stall_t0");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h4C);
        step("ce_low");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h4C);
        step("stall_release");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
        step("midirq_ignored");

        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hEA);
        step("irq_fetch");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        step("irq_pulse_end");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hE8);
        step("irq_clear");

        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
        for (int i = 0; i < 2; i++) step("to_t2");
        step("at_t3");
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge GlobalClock);
        Reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  1'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, 8'($urandom));
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
